// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: FSM state encoding, data width and capture region defaults
// used by both the write and read paths.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GO        = 2'b01,
    FILL      = 2'b10,
    WAIT_DONE = 2'b11
  } sdram_state_t;

  localparam int unsigned SDRAM_DATA_W       = 32;
  localparam logic [31:0] SDRAM_BASE_ADDR    = 32'h0000_0000;
  localparam logic [31:0] SDRAM_REGION_BYTES = 32'h0001_0000;

endpackage

// File: rtl/sdram_write.sv
// Burst writer: streams capture samples into a circular SDRAM region via the write master.
// Optional SDRAM_WRITE_DROP_CNT_EN adds a saturating drop_count output.
module sdram_write
  import sdram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = SDRAM_BASE_ADDR,
  parameter logic [31:0] REGION_BYTES = SDRAM_REGION_BYTES,
  parameter logic [31:0] BURST_BYTES  = 32'd64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_write,
  input  logic                    sample_valid,
  input  logic [SDRAM_DATA_W-1:0] sample_data,
  output logic                    sample_ready,
  output logic                    control_fixed_location,
  output logic [31:0]             control_write_base,
  output logic [31:0]             control_write_length,
  output logic                    control_go,
  input  logic                    control_done,
  output logic                    user_write_buffer,
  output logic [SDRAM_DATA_W-1:0] user_buffer_data,
  input  logic                    user_buffer_full,
  output logic                    busy,
  output logic                    write_done,
  output logic                    overrun,
`ifdef SDRAM_WRITE_DROP_CNT_EN
  output logic [15:0]             drop_count,
`endif
  output logic [31:0]             wr_address
);

  localparam int unsigned WORDS = BURST_BYTES / 4;
  localparam int unsigned CNT_W = $clog2(WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORDS);

  sdram_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_wr_address;
  logic             r_go;
  logic             r_write_done;
  logic             r_overrun;

  logic             w_ready;
  logic             w_push;
  logic             w_drop;
  logic [31:0]      w_next_addr;
  logic [31:0]      w_region_end;

  assign w_ready      = (r_state == FILL) && (r_cnt != '0) && !user_buffer_full;
  assign w_push       = sample_valid && w_ready;
  assign w_drop       = sample_valid && !w_ready;
  assign w_next_addr  = r_wr_address + BURST_BYTES;
  assign w_region_end = BASE_ADDR + REGION_BYTES;

  assign sample_ready           = w_ready;
  assign user_write_buffer      = w_push;
  assign user_buffer_data       = sample_data;
  assign control_fixed_location = 1'b0;
  assign control_write_base     = r_wr_address;
  assign control_write_length   = BURST_BYTES;
  assign control_go             = r_go;
  assign busy                   = (r_state != IDLE);
  assign write_done             = r_write_done;
  assign overrun                = r_overrun;
  assign wr_address             = r_wr_address;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_wr_address <= BASE_ADDR;
      r_go         <= 1'b0;
      r_write_done <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_go         <= 1'b0;
      r_write_done <= 1'b0;
      if (w_drop)
        r_overrun <= 1'b1;
      case (r_state)
        IDLE: begin
          // control_go is raised on entry so it is high for exactly the GO cycle
          if (start_write) begin
            r_state <= GO;
            r_go    <= 1'b1;
          end
        end
        GO: begin
          r_cnt   <= CNT_LOAD;
          r_state <= FILL;
        end
        FILL: begin
          if (w_push) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1))
              r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (control_done) begin
            r_wr_address <= (w_next_addr == w_region_end) ? BASE_ADDR : w_next_addr;
            r_write_done <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_WRITE_DROP_CNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_drop_count <= '0;
    else if (w_drop && (r_drop_count != '1))
      r_drop_count <= r_drop_count + 16'd1;
  end

  assign drop_count = r_drop_count;
`endif

endmodule

// File: doc/sdram_write.md
# sdram_write

Burst writer that streams 32-bit ADC capture samples into SDRAM through the write-master template interface. It is the write-side counterpart of the SDRAM read path: it fills a circular capture region that the read path later drains toward SPI. Each `start_write` launches one fixed-length burst at the current write address, then advances the address and wraps it inside the region.

## Interface
- `BASE_ADDR`, 32'h0: byte address of the capture region start.
- `REGION_BYTES`, 32'h0001_0000: region size in bytes; a multiple of `BURST_BYTES`.
- `BURST_BYTES`, 64: bytes per burst; a multiple of 4 (words = `BURST_BYTES`/4, at least 1).
- `clk` in 1: system clock; every register updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start_write` in 1: request one burst; sampled in IDLE only.
- `sample_valid` in 1: `sample_data` is present this cycle; the source cannot stall.
- `sample_data` in 32: capture word.
- `sample_ready` out 1: the word offered this cycle is accepted.
- `control_fixed_location` out 1: tied 0 (incrementing address).
- `control_write_base` out 32: burst base address, which equals the current write address.
- `control_write_length` out 32: constant `BURST_BYTES`.
- `control_go` out 1: one-cycle burst launch.
- `control_done` in 1: master has finished the burst.
- `user_write_buffer` out 1: push strobe into the master FIFO.
- `user_buffer_data` out 32: push data.
- `user_buffer_full` in 1: master FIFO full.
- `busy` out 1: state is not IDLE.
- `write_done` out 1: one-cycle pulse when a burst completes.
- `overrun` out 1: sticky flag, set when a valid sample is dropped; cleared only by reset.
- `wr_address` out 32: next burst base address.

## Operation
- States: IDLE, GO, FILL, WAIT_DONE.
- IDLE → GO when `start_write`=1.
- GO: `control_go`=1 for this cycle only; the word counter loads `BURST_BYTES`/4. Next state is FILL.
- FILL: `sample_ready` = (word counter ≠ 0) && !`user_buffer_full`.
  - `user_write_buffer` = `sample_valid` && `sample_ready`. It is combinational, with `user_buffer_data` = `sample_data`.
  - Each push decrements the counter.
  - The push that takes the counter to 0 moves the state to WAIT_DONE.
- WAIT_DONE: on `control_done`=1:
  - `wr_address` += `BURST_BYTES`; if the result equals `BASE_ADDR`+`REGION_BYTES`, it becomes `BASE_ADDR`.
  - `write_done` pulses for one cycle.
  - State → IDLE.
- If `start_write` is still high, the next burst launches from IDLE one cycle later; `start_write` is level-sensitive.
- Drops: `overrun` is set by `sample_valid`=1 && `sample_ready`=0 in any state, including IDLE, GO and WAIT_DONE.
- `control_done` in any state other than WAIT_DONE is ignored.
- `user_buffer_full` and `sample_valid` asserted in the same cycle: no push, and the sample is dropped.
- Address arithmetic is 32-bit unsigned, and the wrap compare uses the full 32 bits.

## Timing
- Reset values:
  - state IDLE
  - `wr_address`=`BASE_ADDR`
  - `control_go`, `user_write_buffer`, `sample_ready`, `busy`, `write_done`, `overrun` = 0
  - word counter 0
- `start_write` sampled high at edge k: GO during cycle k+1 (`control_go`=1), FILL from cycle k+2.
- The first push can occur in cycle k+2.
- Push latency is 0 cycles: the data is presented in the same cycle it is accepted.
- `control_done` seen at edge m: `write_done`=1 and the updated `wr_address` appear in cycle m+1, and state is IDLE.
- Minimum burst period with continuous valid samples and no full: 2 + N + (done latency) + 1 cycles, where N = word count.
- Reset asserted mid-burst aborts immediately to reset values. The master's in-flight transfer is not cancelled, and the partial burst data is discarded.

## Configuration
- `SDRAM_WRITE_DROP_CNT_EN`
  - Defined: adds output `drop_count` [15:0]. It increments on every dropped sample, saturates at 16'hFFFF, and resets to 0. `overrun` is still provided.
  - Undefined: no `drop_count` port and no counter logic; only the sticky `overrun` flag.

## Structure
- Shared package `sdram_pkg`:
  - state encoding constants IDLE=2'b00, GO=2'b01, FILL=2'b10, WAIT_DONE=2'b11
  - data width constant (32)
  - default base address and region size constants, shared with the read path so both ends agree on the region.
- No sub-module: a single FSM with a counter and an address register.
- The address wrap logic is small enough to stay inline.

## Test plan
All scenarios use `BURST_BYTES`=64 (16 words), `REGION_BYTES`=128 and `BASE_ADDR`=0.
- Single burst: pulse `start_write`, drive 16 valid samples 0x100..0x10F continuously, assert `control_done` 3 cycles after the last push.
  - `control_go` is high exactly once, with base 0x0.
  - 16 pushes occur, with data in order.
  - `write_done` pulses once.
  - `wr_address` becomes 0x40.
- Wrap: run two bursts. After the second, `wr_address` is 0x0 and the second burst's base is 0x40.
- Backpressure: hold `user_buffer_full`=1 for pushes 5–8 while samples stay valid.
  - No push occurs during the full cycles.
  - `overrun` becomes 1.
  - The burst still completes after 16 accepted words.
  - With the macro defined, `drop_count`=4.
- Idle samples: drive `sample_valid` with no `start_write`. There are no pushes, `overrun`=1 and `busy`=0.
- Reset mid-FILL: after 7 pushes, assert `reset` for 1 cycle.
  - All outputs return to their reset values and `wr_address`=0.
  - A new `start_write` launches a burst with base 0x0.
- Stray done: `control_done`=1 during FILL. No state change, and the counter continues.
